// File: rtl/banco_registros_param_if.sv
// Bus bundle between the pipeline (master) and the parametrised register bank (slave).
// The master drives read/write addresses, write data and the write enable; the slave returns read data and busy.
interface banco_registros_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [NREAD*ADDR_W-1:0] readReg;
  logic [NREAD*WIDTH-1:0]  readData;
  logic [ADDR_W-1:0]       writeReg;
  logic [WIDTH-1:0]        writeData;
  logic                    RegWrite;
  logic                    busy;

  modport master (
    output readReg, writeReg, writeData, RegWrite,
    input  readData, busy
  );

  modport slave (
    input  readReg, writeReg, writeData, RegWrite,
    output readData, busy
  );
endinterface

// File: rtl/banco_registros_param.sv
// Parametrised integer register bank with a post-reset clear sequencer,
// optional hardwired-zero entry 0 and optional same-cycle write-to-read bypass.
module banco_registros_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic                    CLK,
  input logic                    RESET,
  banco_registros_param_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] START_IDX = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy;
  logic              clr_we;
  logic              usr_we;
  logic [WIDTH-1:0]  rd_flat;
  logic [NREAD*WIDTH-1:0] rd_all;

  // Data storage carries no reset; the sequencer is the only thing that zeroes it.
  logic [WIDTH-1:0]  mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= CLEAR;
      idx_q   <= START_IDX;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) state_d = IDLE;
      end
      IDLE:    state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  // Entry 0 is never written when hardwired to zero, so reads must never expose it.
  always_comb begin
    busy   = (state_q != IDLE);
    clr_we = (state_q == CLEAR) && !RESET;
    usr_we = (state_q == IDLE) && !RESET && bus.RegWrite &&
             !((ZERO_REG != 0) && (bus.writeReg == '0));
  end

  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem_q[idx_q] <= '0;
    end else if (usr_we) begin
      mem_q[bus.writeReg] <= bus.writeData;
    end
  end

  always_comb begin
    rd_all  = '0;
    rd_flat = '0;
    for (int i = 0; i < NREAD; i++) begin
      logic [ADDR_W-1:0] ra;
      ra = bus.readReg[i*ADDR_W +: ADDR_W];
      if (busy) begin
        rd_flat = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_flat = '0;
      end else if ((BYPASS != 0) && bus.RegWrite && (ra == bus.writeReg)) begin
        rd_flat = bus.writeData;
      end else begin
        rd_flat = mem_q[ra];
      end
      rd_all[i*WIDTH +: WIDTH] = rd_flat;
    end
  end

  assign bus.readData = rd_all;
  assign bus.busy     = busy;
endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench for banco_registros_param: three configurations share clock and reset;
// expected read/busy values are queued when stimulus is applied and checked at the falling edge.
module tb_banco_registros_param;
  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  banco_registros_param_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) if_a ();
  banco_registros_param_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) if_b ();
  banco_registros_param_if #(.WIDTH(16), .DEPTH(8),  .NREAD(4)) if_c ();

  banco_registros_param #(.WIDTH(32), .DEPTH(32), .NREAD(2), .BYPASS(1), .ZERO_REG(1)) u_a (
    .CLK(CLK), .RESET(RESET), .bus(if_a.slave));
  banco_registros_param #(.WIDTH(32), .DEPTH(32), .NREAD(2), .BYPASS(0), .ZERO_REG(1)) u_b (
    .CLK(CLK), .RESET(RESET), .bus(if_b.slave));
  banco_registros_param #(.WIDTH(16), .DEPTH(8), .NREAD(4), .BYPASS(1), .ZERO_REG(0)) u_c (
    .CLK(CLK), .RESET(RESET), .bus(if_c.slave));

  typedef struct {
    string       tag;
    int          dut;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // port < 0 selects the busy flag
  function automatic logic [31:0] observe(int d, int p);
    if (p < 0) begin
      case (d)
        0:       return {31'b0, if_a.busy};
        1:       return {31'b0, if_b.busy};
        default: return {31'b0, if_c.busy};
      endcase
    end
    case (d)
      0:       return if_a.readData[p*32 +: 32];
      1:       return if_b.readData[p*32 +: 32];
      default: return {16'h0, if_c.readData[p*16 +: 16]};
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] o, logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, o, e);
    end
  endtask

  task automatic push(string tag, int d, int p, logic [31:0] e);
    exp_t x;
    x.tag  = tag;
    x.dut  = d;
    x.port = p;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    @(negedge CLK);
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check(x.tag, observe(x.dut, x.port), x.exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv_a(logic rw, logic [4:0] wr, logic [31:0] wd, logic [4:0] r0, logic [4:0] r1);
    if_a.RegWrite  = rw;
    if_a.writeReg  = wr;
    if_a.writeData = wd;
    if_a.readReg   = {r1, r0};
  endtask

  task automatic drv_b(logic rw, logic [4:0] wr, logic [31:0] wd, logic [4:0] r0, logic [4:0] r1);
    if_b.RegWrite  = rw;
    if_b.writeReg  = wr;
    if_b.writeData = wd;
    if_b.readReg   = {r1, r0};
  endtask

  // Counts falling edges with busy high, bounded so a stuck busy shows up as a wrong count.
  task automatic count_busy(output int ca, output int cb, output int cc);
    ca = 0;
    cb = 0;
    cc = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge CLK);
      if (if_a.busy) ca++;
      if (if_b.busy) cb++;
      if (if_c.busy) cc++;
      if (!if_a.busy && !if_b.busy && !if_c.busy) break;
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    int ca, cb, cc;

    RESET = 1'b1;
    drv_a(1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
    drv_b(1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
    if_c.RegWrite  = 1'b0;
    if_c.writeReg  = 3'd0;
    if_c.writeData = 16'h0;
    if_c.readReg   = {3'd4, 3'd3, 3'd2, 3'd1};

    // reset state
    nxt();
    push("rst_busy_a", 0, -1, 32'h1);
    push("rst_busy_b", 1, -1, 32'h1);
    push("rst_busy_c", 2, -1, 32'h1);
    push("rst_rd_a0", 0, 0, 32'h0);
    push("rst_rd_a1", 0, 1, 32'h0);
    push("rst_rd_b0", 1, 0, 32'h0);
    for (int p = 0; p < 4; p++) push($sformatf("rst_rd_c%0d", p), 2, p, 32'h0);
    drain();
    nxt();
    RESET = 1'b0;

    // clear length after reset release
    count_busy(ca, cb, cc);
    check("clr_len_a", 32'(ca), 32'd31);
    check("clr_len_b", 32'(cb), 32'd31);
    check("clr_len_c", 32'(cc), 32'd8);

    for (int i = 1; i < 32; i++) begin
      nxt();
      drv_a(1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
      push($sformatf("sweep_x%0d", i), 0, 0, 32'h0);
      push($sformatf("sweep_x%0d", 32 - i), 0, 1, 32'h0);
      drain();
    end
    nxt();
    if_c.readReg = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int p = 0; p < 4; p++) push($sformatf("c_sweep_lo%0d", p), 2, p, 32'h0);
    drain();
    nxt();
    if_c.readReg = {3'd7, 3'd6, 3'd5, 3'd4};
    for (int p = 0; p < 4; p++) push($sformatf("c_sweep_hi%0d", p), 2, p, 32'h0);
    drain();

    // writes to x5 and to hardwired-zero x0
    nxt();
    drv_a(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    push("wr5_byp", 0, 0, 32'hDEADBEEF);
    push("x0_before", 0, 1, 32'h0);
    drain();
    nxt();
    drv_a(1'b1, 5'd0, 32'h12345678, 5'd5, 5'd0);
    push("x5_stored", 0, 0, 32'hDEADBEEF);
    push("x0_during_wr", 0, 1, 32'h0);
    drain();
    nxt();
    drv_a(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    push("x5_after", 0, 0, 32'hDEADBEEF);
    push("x0_after", 0, 1, 32'h0);
    drain();

    // bypass versus no bypass on x7
    nxt();
    drv_a(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
    drv_b(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
    push("byp_a0", 0, 0, 32'hA5A5A5A5);
    push("byp_a1", 0, 1, 32'hA5A5A5A5);
    push("nobyp_b0", 1, 0, 32'h0);
    push("nobyp_b1", 1, 1, 32'h0);
    drain();
    nxt();
    drv_a(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    drv_b(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    push("x7_a0", 0, 0, 32'hA5A5A5A5);
    push("x7_a1", 0, 1, 32'hA5A5A5A5);
    push("x7_b0", 1, 0, 32'hA5A5A5A5);
    push("x7_b1", 1, 1, 32'hA5A5A5A5);
    drain();

    // writes during clear are dropped and reset re-zeroes everything
    nxt();
    drv_a(1'b1, 5'd3, 32'h55, 5'd3, 5'd5);
    push("x3_wr", 0, 0, 32'h55);
    drain();
    nxt();
    drv_a(1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
    push("x3_stored", 0, 0, 32'h55);
    drain();
    nxt();
    RESET = 1'b1;
    nxt();
    RESET = 1'b0;
    drv_a(1'b1, 5'd3, 32'h99, 5'd3, 5'd5);
    for (int k = 0; k < 5; k++) begin
      push($sformatf("busy_wr_busy%0d", k), 0, -1, 32'h1);
      push($sformatf("busy_wr_rd%0d", k), 0, 0, 32'h0);
      drain();
      if (k < 4) nxt();
    end
    nxt();
    drv_a(1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
    count_busy(ca, cb, cc);
    check("clr2_len_a", 32'(ca), 32'd26);
    check("clr2_len_b", 32'(cb), 32'd26);
    check("clr2_len_c", 32'(cc), 32'd3);
    nxt();
    drv_b(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    push("x3_cleared", 0, 0, 32'h0);
    push("x5_cleared", 0, 1, 32'h0);
    push("b_x7_cleared", 1, 0, 32'h0);
    drain();

    // reset re-asserted partway through clear restarts it
    nxt();
    RESET = 1'b1;
    nxt();
    RESET = 1'b0;
    repeat (9) nxt();
    push("mid_busy_a", 0, -1, 32'h1);
    push("mid_busy_b", 1, -1, 32'h1);
    drain();
    nxt();
    RESET = 1'b1;
    push("rst2_busy_a", 0, -1, 32'h1);
    drain();
    nxt();
    RESET = 1'b0;
    count_busy(ca, cb, cc);
    check("restart_len_a", 32'(ca), 32'd31);
    check("restart_len_b", 32'(cb), 32'd31);
    check("restart_len_c", 32'(cc), 32'd8);

    // small config: writable x0 on four ports
    nxt();
    if_c.RegWrite  = 1'b1;
    if_c.writeReg  = 3'd0;
    if_c.writeData = 16'h00FF;
    if_c.readReg   = {3'd0, 3'd0, 3'd0, 3'd0};
    for (int p = 0; p < 4; p++) push($sformatf("c_x0_byp%0d", p), 2, p, 32'h00FF);
    drain();
    nxt();
    if_c.RegWrite = 1'b0;
    for (int p = 0; p < 4; p++) push($sformatf("c_x0_rd%0d", p), 2, p, 32'h00FF);
    drain();
    nxt();
    if_c.readReg = {3'd0, 3'd7, 3'd1, 3'd0};
    push("c_mix0", 2, 0, 32'h00FF);
    push("c_mix1", 2, 1, 32'h0);
    push("c_mix2", 2, 2, 32'h0);
    push("c_mix3", 2, 3, 32'h00FF);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
